uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
UART transmit path, the counterpart of the receiver's parity checker. It accepts a parallel byte on a load strobe and serialises it as an 11-bit frame on txout. The frame is: start bit, 8 data bits LSB-first, parity bit, stop bit. It sits between the host-side data source and the serial line, and generates the parity that the receiver-side checker validates.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (must be >= 2)
DATA_WIDTH, 8, data bits per frame
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (inverted XOR)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
load  input  1  start request; sampled only in IDLE
din  input  DATA_WIDTH  byte to transmit; sampled on the accepted load cycle
txout  output  1  serial line, idle high, registered
busy  output  1  high from the cycle after load is accepted until the stop bit completes
done  output  1  one-cycle pulse on the last clk of the stop bit

Behaviour:
- Reset (async, active-high): state=IDLE, txout=1, busy=0, done=0, bit counter=0, baud counter=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txout=1.
  - On a rising clk edge with load=1: latch din into the shift register; latch parity = ^din ^ PARITY_ODD; go to START.
  - busy=1 and txout=0 from the next cycle, so latency from load to the start-bit edge is 1 clk.
- Each bit is held for exactly CLKS_PER_BIT clks.
  - Baud counter counts 0..CLKS_PER_BIT-1.
  - The state or bit advances when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- START: txout=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - txout = shift register bit 0.
  - At each bit end: shift right, bit index +1.
  - After bit index DATA_WIDTH-1 completes, go to PARITY.
- PARITY: txout = latched parity for one bit time, then go to STOP.
- STOP:
  - txout=1 for one bit time.
  - done=1 on its final clk; busy stays 1 through that clk.
  - Next state is IDLE.
- Full frame = (DATA_WIDTH+3)*CLKS_PER_BIT clks (176 at defaults).
- load while busy=1 is ignored; din changes while busy have no effect.
- Back-to-back frames: load held high re-triggers on the first IDLE cycle. The minimum inter-frame gap is 1 clk of idle-high line.
- Reset mid-frame: txout returns to 1 immediately (asynchronously) and the frame is abandoned; no done pulse.
- The bit index counter width is $clog2(DATA_WIDTH).
- The baud counter width is $clog2(CLKS_PER_BIT).

Decomposition:
- Package uart_pkg:
  - state encoding constants S_IDLE..S_STOP (3-bit)
  - PARITY_EVEN/PARITY_ODD constants
  - IDLE_LEVEL=1'b1
  - receiver and transmitter both import this package.
- One sub-module, uart_baud_gen:
  - ports clk, reset, enable, bit_tick
  - bit_tick pulses on the last clk of each bit period
  - the counter is cleared while enable=0
  - the transmitter enables it whenever state != IDLE.

Test Plan:
1. CLKS_PER_BIT=4, even parity. Stimulus: reset pulse, then load=1 for one clk with din=8'b00001001. Required response: txout per 4-clk bit = 0,1,0,0,1,0,0,0,0,0,1. Parity bit is 0. done pulses at clk 44 after load; busy=1 for exactly 44 clks.
2. din=8'h07, even parity. Required response: parity bit=1. With PARITY_ODD=1 and the same din, parity bit=0. Also run din=8'h00 with PARITY_ODD=1: parity bit=1.
3. Load while busy. Stimulus: start a frame with din=8'hA5, then pulse load with din=8'h3C during the DATA state. Required response: frame bits still match 8'hA5; no second frame; single done pulse.
4. Back-to-back. Stimulus: hold load=1 with din=8'h55. Required response: the second start bit falls exactly 1 clk after the first done pulse; both frames are correct.
5. Reset mid-frame. Stimulus: assert reset during the 4th data bit. Required response: txout=1, busy=0, done=0 in the same cycle. A new load afterwards sends a clean full frame.
6. Idle check. Stimulus: 100 clks with load=0 after reset. Required response: txout stays 1, busy=0, done never asserts.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (FSM state encodings, parity sense, idle line level).
// Imported by both the transmitter and the receiver-side parity checker so that
// the two ends agree on state encodings and on what "even"/"odd" parity means.
package uart_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: host-side handshake and serial output of the UART transmitter.
// Signals: load (start request), din (byte to send), txout (serial line),
// busy (frame in progress), done (pulse on the last clk of the stop bit).
// Modports: master = host/data source, slave = transmitter.
interface uart_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  load;
    logic [DATA_WIDTH-1:0] din;
    logic                  txout;
    logic                  busy;
    logic                  done;
    modport master (output load, din, input txout, busy, done);
    modport slave  (input load, din, output txout, busy, done);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer; bit_tick pulses on the last clk of each bit.
// Ports: clk, reset (async, active-high), enable (counter held at 0 while low),
// bit_tick (high when the counter sits at CLKS_PER_BIT-1 and enable is high).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign bit_tick = enable && (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign cnt_d = (!enable || bit_tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises a byte as start, DATA_WIDTH data bits LSB-first, parity, stop.
// Ports: clk, reset (async, active-high), bus (slave modport: load, din, txout, busy, done).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter bit PARITY_ODD   = PARITY_EVEN
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_transmitter_if.slave     bus
);
    localparam int IW = $clog2(DATA_WIDTH);
    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  par_q, par_d;
    logic                  txout_q, txout_d;
    logic                  tick;
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q != S_IDLE),
        .bit_tick (tick)
    );
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: if (bus.load) begin
                state_d = S_START;
                shift_d = bus.din;
                par_d   = (^bus.din) ^ (PARITY_ODD ? uart_pkg::PARITY_ODD : PARITY_EVEN);
            end
            S_START: if (tick) begin
                state_d = S_DATA;
                idx_d   = '0;
            end
            S_DATA: if (tick) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IW'(DATA_WIDTH - 1)) ? S_PARITY : S_DATA;
            end
            S_PARITY: state_d = tick ? S_STOP : S_PARITY;
            S_STOP:   state_d = tick ? S_IDLE : S_STOP;
            default:  state_d = S_IDLE;
        endcase
        // Line level is derived from the next state so txout is a clean register output.
        txout_d = (state_d == S_START)  ? 1'b0 :
                  (state_d == S_DATA)   ? shift_d[0] :
                  (state_d == S_PARITY) ? par_d : IDLE_LEVEL;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            txout_q <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            txout_q <= txout_d;
        end
    end
    assign bus.txout = txout_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = (state_q == S_STOP) && tick;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed self-checking bench for uart_transmitter (even and odd parity instances).
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    uart_transmitter_if #(.DATA_WIDTH(8)) bus_e ();
    uart_transmitter_if #(.DATA_WIDTH(8)) bus_o ();
    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_ODD(0)) dut_e (
        .clk(clk), .reset(reset), .bus(bus_e));
    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_ODD(1)) dut_o (
        .clk(clk), .reset(reset), .bus(bus_o));

    task automatic start(input bit sel, input logic [7:0] d);
        if (sel) begin bus_o.load = 1'b1; bus_o.din = d; end
        else     begin bus_e.load = 1'b1; bus_e.din = d; end
        @(negedge clk);
        bus_o.load = 1'b0;
        bus_e.load = 1'b0;
    endtask

    // Samples 44 cycles of a frame starting at the current negedge (cycle 1 after load).
    task automatic capture(input bit sel, input int inj_at, input logic [7:0] inj_din,
                           output logic [10:0] frame, output bit stable,
                           output int done_at, output int done_cnt, output int busy_cnt);
        logic tx;
        frame = '0; stable = 1'b1; done_at = 0; done_cnt = 0; busy_cnt = 0;
        for (int i = 1; i <= 44; i++) begin
            tx = sel ? bus_o.txout : bus_e.txout;
            if ((i - 1) % 4 == 0) frame[(i - 1) / 4] = tx;
            else if (frame[(i - 1) / 4] !== tx) stable = 1'b0;
            if ((sel ? bus_o.busy : bus_e.busy) === 1'b1) busy_cnt++;
            if ((sel ? bus_o.done : bus_e.done) === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (inj_at != 0) begin
                if (sel) begin bus_o.load = (i == inj_at); if (i == inj_at) bus_o.din = inj_din; end
                else     begin bus_e.load = (i == inj_at); if (i == inj_at) bus_e.din = inj_din; end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus_e.load = 1'b0; bus_e.din = '0;
        bus_o.load = 1'b0; bus_o.din = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus_e.txout !== 1'b1) begin errors++; $display("FAIL reset_txout got %b want 1", bus_e.txout); end
        checks++; if (bus_e.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_e.busy); end
        checks++; if (bus_e.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus_e.done); end
        checks++; if (bus_o.txout !== 1'b1) begin errors++; $display("FAIL reset_txout_odd got %b want 1", bus_o.txout); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame;
        logic [10:0] f; bit st; int da, dc, bc;
        start(0, 8'b0000_1001);
        capture(0, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_0_00001001_0) begin errors++; $display("FAIL frame_09 got %b want %b", f, 11'b1_0_00001001_0); end
        checks++; if (!st) begin errors++; $display("FAIL frame_09_bit_width got unstable want 4-clk bits"); end
        checks++; if (da != 44) begin errors++; $display("FAIL frame_09_done_at got %0d want 44", da); end
        checks++; if (dc != 1) begin errors++; $display("FAIL frame_09_done_count got %0d want 1", dc); end
        checks++; if (bc != 44) begin errors++; $display("FAIL frame_09_busy_clks got %0d want 44", bc); end
        checks++; if (bus_e.busy !== 1'b0 || bus_e.txout !== 1'b1) begin
            errors++; $display("FAIL frame_09_after busy=%b txout=%b want busy=0 txout=1", bus_e.busy, bus_e.txout); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_parity;
        logic [10:0] f; bit st; int da, dc, bc;
        start(0, 8'h07);
        capture(0, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_1_00000111_0) begin errors++; $display("FAIL parity_even_07 got %b want %b", f, 11'b1_1_00000111_0); end
        @(negedge clk);
        start(1, 8'h07);
        capture(1, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_0_00000111_0) begin errors++; $display("FAIL parity_odd_07 got %b want %b", f, 11'b1_0_00000111_0); end
        checks++; if (dc != 1) begin errors++; $display("FAIL parity_odd_07_done got %0d want 1", dc); end
        @(negedge clk);
        start(1, 8'h00);
        capture(1, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_1_00000000_0) begin errors++; $display("FAIL parity_odd_00 got %b want %b", f, 11'b1_1_00000000_0); end
        @(negedge clk);
    endtask

    task automatic test_load_while_busy;
        logic [10:0] f; bit st; int da, dc, bc, extra;
        start(0, 8'hA5);
        capture(0, 10, 8'h3C, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_0_10100101_0) begin errors++; $display("FAIL busy_load_frame got %b want %b", f, 11'b1_0_10100101_0); end
        checks++; if (dc != 1) begin errors++; $display("FAIL busy_load_done got %0d want 1", dc); end
        extra = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_e.busy !== 1'b0 || bus_e.done !== 1'b0 || bus_e.txout !== 1'b1) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_load_second_frame got %0d active clks want 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] f; bit st; int da, dc, bc;
        bus_e.load = 1'b1; bus_e.din = 8'h55;
        @(negedge clk);
        capture(0, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_0_01010101_0) begin errors++; $display("FAIL b2b_frame1 got %b want %b", f, 11'b1_0_01010101_0); end
        checks++; if (da != 44) begin errors++; $display("FAIL b2b_done1_at got %0d want 44", da); end
        checks++; if (bus_e.txout !== 1'b1 || bus_e.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_gap txout=%b busy=%b want txout=1 busy=0", bus_e.txout, bus_e.busy); end
        @(negedge clk);
        bus_e.load = 1'b0;
        checks++; if (bus_e.txout !== 1'b0 || bus_e.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_start2 txout=%b busy=%b want txout=0 busy=1", bus_e.txout, bus_e.busy); end
        capture(0, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_0_01010101_0) begin errors++; $display("FAIL b2b_frame2 got %b want %b", f, 11'b1_0_01010101_0); end
        checks++; if (dc != 1) begin errors++; $display("FAIL b2b_done2 got %0d want 1", dc); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [10:0] f; bit st; int da, dc, bc;
        start(0, 8'hF0);
        repeat (17) @(negedge clk);
        checks++; if (bus_e.busy !== 1'b1 || bus_e.txout !== 1'b0) begin
            errors++; $display("FAIL midreset_before busy=%b txout=%b want busy=1 txout=0", bus_e.busy, bus_e.txout); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_e.txout !== 1'b1) begin errors++; $display("FAIL midreset_txout got %b want 1", bus_e.txout); end
        checks++; if (bus_e.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus_e.busy); end
        checks++; if (bus_e.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus_e.done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start(0, 8'hC3);
        capture(0, 0, 8'h00, f, st, da, dc, bc);
        checks++; if (f !== 11'b1_0_11000011_0) begin errors++; $display("FAIL midreset_new_frame got %b want %b", f, 11'b1_0_11000011_0); end
        checks++; if (!st || dc != 1 || bc != 44) begin
            errors++; $display("FAIL midreset_new_timing stable=%0d done=%0d busy=%0d want 1/1/44", st, dc, bc); end
        @(negedge clk);
    endtask

    task automatic test_idle;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (bus_e.txout !== 1'b1 || bus_e.busy !== 1'b0 || bus_e.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_clk%0d txout=%b busy=%b done=%b want 1/0/0", i, bus_e.txout, bus_e.busy, bus_e.done);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_frame;
        test_parity;
        test_load_while_busy;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
